// File: rtl/rv32e_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rv32e_fetch_buffer
// Brief    : RV32E instruction prefetch buffer with redirect-safe response drop.
// Revision : 1.0
// ============================================================================
module rv32e_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h80000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int                 c_ptr_w     = $clog2(DEPTH);
  localparam int                 c_cnt_w     = c_ptr_w + 1;
  localparam logic [c_cnt_w:0]   c_depth_ext = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);
  localparam logic [31:0]        c_nop       = 32'h00000013;
  localparam logic [31:0]        c_pc_mask   = 32'hFFFFFFFC;

  logic [31:0]         r_fetch_pc;
  logic [31:0]         r_resp_pc;
  logic [c_cnt_w-1:0]  r_count;
  logic [1:0]          r_outstanding;
  logic [1:0]          r_drop_cnt;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [31:0]         r_fifo_data [DEPTH];
  logic [31:0]         r_fifo_pc   [DEPTH];

  logic [c_cnt_w:0]    w_inflight;
  logic                w_fire;
  logic                w_rsp;
  logic                w_drop;
  logic                w_push;
  logic                w_pop;
  logic [1:0]          w_outstanding_nxt;
  logic [31:0]         w_redirect_pc;

  // Credits cover both buffered entries and in-flight responses, so a
  // returning word always has a free slot.
  assign w_inflight = {1'b0, r_count} + {{(c_cnt_w - 1){1'b0}}, r_outstanding};

  assign mem_req  = rst_n && !redirect_valid && (r_outstanding < 2'd2)
                    && (w_inflight < c_depth_ext);
  assign mem_addr = r_fetch_pc;

  assign w_fire        = mem_req && mem_gnt;
  assign w_rsp         = mem_rvalid && (r_outstanding != 2'd0);
  assign w_drop        = w_rsp && (r_drop_cnt != 2'd0);
  assign w_push        = w_rsp && !w_drop && !redirect_valid;
  assign w_pop         = instr_valid && instr_ready && !redirect_valid;
  assign w_redirect_pc = redirect_pc & c_pc_mask;

  always_comb begin
    w_outstanding_nxt = r_outstanding;
    case ({w_fire, w_rsp})
      2'b10:   w_outstanding_nxt = r_outstanding + 2'd1;
      2'b01:   w_outstanding_nxt = r_outstanding - 2'd1;
      default: w_outstanding_nxt = r_outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= 2'd0;
      r_drop_cnt    <= 2'd0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect_valid) begin
        // Every response still owed by memory belongs to the old stream;
        // a response landing this very cycle is already discarded here.
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_drop_cnt <= r_outstanding - {1'b0, w_rsp};
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_fire) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_drop) begin
          r_drop_cnt <= r_drop_cnt - 2'd1;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= mem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

  assign instr_valid = (r_count != '0);
  assign instr_data  = instr_valid ? r_fifo_data[r_rd_ptr] : c_nop;
  assign instr_pc    = instr_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

`ifndef SYNTHESIS
  logic        r_chk_req_pend;
  logic [31:0] r_chk_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chk_req_pend <= 1'b0;
      r_chk_addr     <= 32'h0;
    end else begin
      assert (!(w_push && !w_pop && (r_count == c_depth_cnt)))
        else $error("fetch buffer overflow");
      assert (!(mem_rvalid && (r_outstanding == 2'd0)))
        else $error("mem_rvalid with no request outstanding");
      // An ungranted request may only be withdrawn by a redirect.
      if (r_chk_req_pend && !redirect_valid) begin
        assert (mem_req && (mem_addr == r_chk_addr))
          else $error("ungranted request changed");
      end
      r_chk_req_pend <= mem_req && !mem_gnt;
      r_chk_addr     <= mem_addr;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/rv32e_fetch_buffer.md
Name: rv32e_fetch_buffer

Overview:
- Instruction prefetch stage between the instruction memory/bus and the RV32E pipeline IF stage.
- Issues sequential fetch requests over a req/gnt/rvalid memory handshake, with up to 2 requests outstanding.
- Buffers returned words in a small FIFO and hands {instr, pc} to the core over a valid/ready interface.
- Discards in-flight data on a core redirect (branch/jump).

Parameters:
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- RESET_PC, 32'h80000000, first fetch address after reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset
- mem_req  output  1  fetch request valid
- mem_addr  output  32  fetch address, word aligned
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  32  read data
- redirect_valid  input  1  core redirect strobe
- redirect_pc  input  32  new fetch address, [1:0] ignored (forced 0)
- instr_valid  output  1  FIFO head valid
- instr_data  output  32  FIFO head instruction
- instr_pc  output  32  FIFO head address
- instr_ready  input  1  core consumes head

Behaviour:
- Interface decision: reset rst_n, asynchronous, active-low; clock clk.
- Reset state:
  - fetch_pc=RESET_PC, resp_pc=RESET_PC.
  - FIFO count=0, outstanding=0, drop_cnt=0.
  - mem_req=0, instr_valid=0, instr_data=32'h00000013 (NOP), instr_pc=0.
  - The memory side shares rst_n; no response may arrive for a pre-reset request.
- Issue rule (combinational):
  - mem_req = !redirect_valid && outstanding<2 && (count+outstanding)<DEPTH.
  - mem_addr = fetch_pc.
  - Handshake fires on mem_req && mem_gnt: fetch_pc += 4, outstanding += 1.
  - mem_req and mem_addr stay stable until gnt, except when a redirect aborts an ungranted request (permitted).
- Response rule:
  - Responses return in order, no earlier than the cycle after gnt; outstanding -= 1 on each mem_rvalid.
  - If drop_cnt>0: discard the data, drop_cnt -= 1.
  - Else: push {mem_rdata, resp_pc}, resp_pc += 4.
  - The credit check guarantees the FIFO never overflows; a push when full is an assertion failure.
- mem_rvalid with outstanding==0 is a protocol error: assert, ignore the data.
- Core side:
  - instr_valid = count>0.
  - instr_data/instr_pc = head entry; when empty, NOP and 0.
  - Pop on instr_valid && instr_ready && !redirect_valid.
  - Push and pop in the same cycle: count unchanged, head advances; allowed at count==DEPTH.
  - A push into an empty FIFO is visible at the output the next cycle (1-cycle rvalid→instr_valid latency).
- Redirect (single-cycle strobe, highest priority):
  - FIFO cleared (count=0); a pop in the same cycle is ignored.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding − (mem_rvalid?1:0); the same-cycle response is discarded.
  - outstanding keeps counting the dropped responses, so credits stay honest.
  - The first new request goes out the next cycle if credits allow.
  - Back-to-back redirects: each recomputes drop_cnt the same way; the last one wins.
- Counter widths: outstanding/drop_cnt 2 bits, count $clog2(DEPTH)+1 bits. PCs wrap modulo 2^32 (0xFFFFFFFC+4 = 0).
- Throughput:
  - Zero-wait memory (gnt same cycle, rvalid next cycle) with the core always ready gives 1 instr/cycle after a 2-cycle startup.
  - First instr_valid occurs 2 cycles after reset release.

Test Plan:
- Reset then zero-wait memory returning mem_rdata=addr, instr_ready=1 → instr_pc sequence 0x80000000, 0x80000004, …; instr_data==instr_pc; one instr/cycle from the 3rd cycle.
- instr_ready=0 for 20 cycles → count saturates at 4 with outstanding=0, mem_req=0; release → 4 buffered entries drain in order with no gap, then streaming resumes.
- Memory gnt every 3rd cycle, rvalid 4 cycles later → never more than 2 outstanding; order preserved; no FIFO overflow assertion.
- Redirect to 0x00000100 with 2 outstanding and 1 rvalid in the same cycle → those 2 responses never appear; next instr_pc=0x00000100; no stale instr_valid in the cycle after the redirect.
- Redirect coincides with instr_ready=1 and count=3 → no pop counted, FIFO empty next cycle; redirect_pc=0x00000102 fetches 0x00000100.
- Assert rst_n low with 2 requests outstanding and the FIFO full → all outputs return to reset values immediately; after release, fetch restarts at 0x80000000.
